// File: rtl/command_frame_assembler.sv
// Command frame assembler: collects FRAME_WORDS received words (command,
// address, VALUE_WORDS value words) into one wide frame and presents it with
// a one-cycle valid pulse. A partial frame that goes quiet for TIMEOUT_CYCLES
// clocks is discarded and flagged with a one-cycle timeout pulse.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | no words held; idle counter parked at 0
// S_COLLECT | 1..FRAME_WORDS-1 words held; idle counter guards the gap

module command_frame_assembler #(
   parameter int  WORD_WIDTH     = 8,
   parameter int  VALUE_WORDS    = 4,
   parameter int  TIMEOUT_CYCLES = 1000,
   localparam int FRAME_WORDS    = VALUE_WORDS + 2,
   localparam int FRAME_BITS     = FRAME_WORDS * WORD_WIDTH,
   localparam int CNT_W          = $clog2(FRAME_WORDS + 1)
) (
   input  logic                  clk,
   input  logic                  i_reset,
   input  logic [WORD_WIDTH-1:0] i_word,
   input  logic                  i_word_dv,
   output logic [FRAME_BITS-1:0] o_data,
   output logic                  o_dv,
   output logic                  o_busy,
   output logic                  o_timeout,
   output logic [CNT_W-1:0]      o_word_count
);

   // The shift register only needs the words preceding the last one; the
   // last word is appended combinationally when the frame is loaded.
   localparam int SH_BITS = FRAME_BITS - WORD_WIDTH;
   localparam int IDLE_W  = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(FRAME_WORDS - 1);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic {
      S_IDLE    = 1'b0,
      S_COLLECT = 1'b1
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [SH_BITS-1:0]  shreg;
   logic [FRAME_BITS-1:0] frame_nxt;
   logic [CNT_W-1:0]    word_cnt;
   logic [IDLE_W-1:0]   idle_cnt;
   logic                last_word;
   logic                expire;

   assign frame_nxt = {shreg, i_word};
   assign last_word = i_word_dv && (word_cnt == LAST_WORD);
   // A word in the would-be expiry cycle wins, hence the !i_word_dv term.
   assign expire    = (state == S_COLLECT) && !i_word_dv && (idle_cnt == IDLE_LAST);

   // State register.
   always_ff @(posedge clk or posedge i_reset) begin
      if (i_reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode: first word opens a frame, last word or expiry closes it.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (i_word_dv) begin
               state_nxt = S_COLLECT;
            end
         end
         S_COLLECT: begin
            if (last_word || expire) begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Status outputs derived from the current state and word counter.
   always_comb begin
      o_busy       = (state == S_COLLECT);
      o_word_count = word_cnt;
   end

   // Word capture, word/idle counters, frame load and the two output pulses.
   always_ff @(posedge clk or posedge i_reset) begin
      if (i_reset) begin
         shreg     <= '0;
         word_cnt  <= '0;
         idle_cnt  <= '0;
         o_data    <= '0;
         o_dv      <= 1'b0;
         o_timeout <= 1'b0;
      end else begin
         o_dv      <= 1'b0;
         o_timeout <= 1'b0;
         if (i_word_dv) begin
            shreg    <= frame_nxt[SH_BITS-1:0];
            idle_cnt <= '0;
            if (last_word) begin
               o_data   <= frame_nxt;
               o_dv     <= 1'b1;
               word_cnt <= '0;
            end else begin
               word_cnt <= word_cnt + 1'b1;
            end
         end else if (state == S_COLLECT) begin
            if (expire) begin
               idle_cnt  <= '0;
               word_cnt  <= '0;
               o_timeout <= 1'b1;
            end else begin
               idle_cnt <= idle_cnt + 1'b1;
            end
         end else begin
            idle_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_command_frame_assembler.sv
// Bench for command_frame_assembler with default parameters: directed vector
// table, hand-written multi-cycle sequences, a downstream command decoder,
// and randomized traffic against a queue-based reference model.

module tb_command_frame_assembler;

   localparam int T = 1000;

   logic        clk = 1'b0;
   logic        i_reset;
   logic [7:0]  i_word;
   logic        i_word_dv;
   logic [47:0] o_data;
   logic        o_dv;
   logic        o_busy;
   logic        o_timeout;
   logic [2:0]  o_word_count;

   always #5 clk = ~clk;

   command_frame_assembler #(
      .WORD_WIDTH     (8),
      .VALUE_WORDS    (4),
      .TIMEOUT_CYCLES (T)
   ) dut (
      .clk          (clk),
      .i_reset      (i_reset),
      .i_word       (i_word),
      .i_word_dv    (i_word_dv),
      .o_data       (o_data),
      .o_dv         (o_dv),
      .o_busy       (o_busy),
      .o_timeout    (o_timeout),
      .o_word_count (o_word_count)
   );

   // Downstream command controller stand-in: write command 0a, read command a0.
   logic w_en = 1'b0;
   logic r_en = 1'b0;
   int   w_pulses = 0;
   int   r_pulses = 0;

   always @(posedge clk or posedge i_reset) begin
      if (i_reset) begin
         w_en <= 1'b0;
         r_en <= 1'b0;
      end else begin
         w_en <= o_dv && (o_data[47:40] == 8'h0a);
         r_en <= o_dv && (o_data[47:40] == 8'ha0);
      end
   end

   always @(posedge clk) begin
      if (w_en) w_pulses <= w_pulses + 1;
      if (r_en) r_pulses <= r_pulses + 1;
   end

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a queue of held words and a count of quiet clocks.
   logic [7:0]  mq[$];
   int          m_idle;
   logic [47:0] m_data;
   logic        m_dv;
   logic        m_to;

   function automatic void model_reset();
      mq.delete();
      m_idle = 0;
      m_data = '0;
      m_dv   = 1'b0;
      m_to   = 1'b0;
   endfunction

   function automatic void model_step(input bit dv, input logic [7:0] w);
      m_dv = 1'b0;
      m_to = 1'b0;
      if (dv) begin
         mq.push_back(w);
         m_idle = 0;
         if (mq.size() == 6) begin
            m_data = '0;
            foreach (mq[i]) m_data = {m_data[39:0], mq[i]};
            m_dv = 1'b1;
            mq.delete();
         end
      end else if (mq.size() > 0) begin
         m_idle++;
         if (m_idle == T) begin
            mq.delete();
            m_idle = 0;
            m_to   = 1'b1;
         end
      end
   endfunction

   task automatic check_model(input string tag);
      chk({tag, " o_dv"},         o_dv,         m_dv);
      chk({tag, " o_timeout"},    o_timeout,    m_to);
      chk({tag, " o_word_count"}, o_word_count, mq.size());
      chk({tag, " o_busy"},       o_busy,       mq.size() != 0);
      chk({tag, " o_data"},       o_data,       m_data);
   endtask

   // Drive one cycle, step the model across the edge, compare 1ns later.
   task automatic edge_step(input bit dv, input logic [7:0] w);
      i_word_dv = dv;
      i_word    = w;
      @(posedge clk);
      #1;
      model_step(dv, w);
      check_model("model");
   endtask

   typedef struct {
      bit          dv;
      logic [7:0]  w;
      bit          e_dv;
      logic [2:0]  e_cnt;
      bit          e_busy;
      logic [47:0] e_data;
   } vec_t;

   vec_t tv[8];

   initial begin
      int p[$];
      int gap;
      int to_seen;
      int to_at;
      int dv_seen;
      int w0;
      int r0;

      tv[0] = '{1'b1, 8'h0a, 1'b0, 3'd1, 1'b1, 48'h0};
      tv[1] = '{1'b1, 8'h05, 1'b0, 3'd2, 1'b1, 48'h0};
      tv[2] = '{1'b1, 8'hde, 1'b0, 3'd3, 1'b1, 48'h0};
      tv[3] = '{1'b1, 8'had, 1'b0, 3'd4, 1'b1, 48'h0};
      tv[4] = '{1'b1, 8'hbe, 1'b0, 3'd5, 1'b1, 48'h0};
      tv[5] = '{1'b1, 8'hef, 1'b1, 3'd0, 1'b0, 48'h0a05deadbeef};
      tv[6] = '{1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 48'h0a05deadbeef};
      tv[7] = '{1'b0, 8'h77, 1'b0, 3'd0, 1'b0, 48'h0a05deadbeef};

      // Reset held across edges with words strobed: everything stays 0.
      i_reset   = 1'b1;
      i_word_dv = 1'b1;
      i_word    = 8'h55;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset o_data",       o_data,       48'h0);
      chk("reset o_dv",         o_dv,         1'b0);
      chk("reset o_busy",       o_busy,       1'b0);
      chk("reset o_timeout",    o_timeout,    1'b0);
      chk("reset o_word_count", o_word_count, 3'd0);
      i_word_dv = 1'b0;
      i_reset   = 1'b0;

      // Single frame from the vector table.
      for (int i = 0; i < 8; i++) begin
         edge_step(tv[i].dv, tv[i].w);
         chk("vec o_dv",         o_dv,         tv[i].e_dv);
         chk("vec o_word_count", o_word_count, tv[i].e_cnt);
         chk("vec o_busy",       o_busy,       tv[i].e_busy);
         chk("vec o_data",       o_data,       tv[i].e_data);
      end

      // Twelve back-to-back words: two pulses six clocks apart.
      for (int k = 0; k < 12; k++) begin
         edge_step(1'b1, 8'(8'h10 + k));
         if (o_dv) p.push_back(k);
      end
      edge_step(1'b0, 8'h00);
      chk("b2b pulse count", p.size(), 2);
      gap = (p.size() == 2) ? (p[1] - p[0]) : -1;
      chk("b2b pulse gap", gap, 6);
      chk("b2b first pulse", (p.size() > 0) ? p[0] : -1, 5);
      chk("b2b o_data", o_data, 48'h161718191a1b);

      // Three words then a full timeout window of silence.
      edge_step(1'b1, 8'h01);
      edge_step(1'b1, 8'h02);
      edge_step(1'b1, 8'h03);
      to_seen = 0;
      to_at   = -1;
      for (int i = 1; i <= T; i++) begin
         edge_step(1'b0, 8'h00);
         if (o_timeout) begin
            to_seen++;
            to_at = i;
         end
      end
      chk("timeout pulses",       to_seen,      1);
      chk("timeout cycle",        to_at,        T);
      chk("timeout o_word_count", o_word_count, 3'd0);
      chk("timeout o_busy",       o_busy,       1'b0);
      chk("timeout o_data",       o_data,       48'h161718191a1b);
      edge_step(1'b0, 8'h00);
      chk("timeout one cycle", o_timeout, 1'b0);
      for (int k = 0; k < 6; k++) edge_step(1'b1, 8'(8'h21 + k));
      chk("after timeout o_dv",   o_dv,   1'b1);
      chk("after timeout o_data", o_data, 48'h212223242526);

      // Word lands on the expiry cycle: captured, no timeout.
      edge_step(1'b1, 8'h31);
      edge_step(1'b1, 8'h32);
      edge_step(1'b1, 8'h33);
      to_seen = 0;
      for (int i = 1; i < T; i++) begin
         edge_step(1'b0, 8'h00);
         if (o_timeout) to_seen++;
      end
      edge_step(1'b1, 8'h34);
      if (o_timeout) to_seen++;
      chk("race timeouts",     to_seen,      0);
      chk("race o_word_count", o_word_count, 3'd4);
      edge_step(1'b1, 8'h35);
      edge_step(1'b1, 8'h36);
      chk("race o_data", o_data, 48'h313233343536);

      // Asynchronous reset pulse between edges in the middle of a frame.
      for (int k = 0; k < 4; k++) edge_step(1'b1, 8'(8'h41 + k));
      i_word_dv = 1'b0;
      #2 i_reset = 1'b1;
      model_reset();
      #1;
      chk("midreset o_data",       o_data,       48'h0);
      chk("midreset o_dv",         o_dv,         1'b0);
      chk("midreset o_busy",       o_busy,       1'b0);
      chk("midreset o_timeout",    o_timeout,    1'b0);
      chk("midreset o_word_count", o_word_count, 3'd0);
      #1 i_reset = 1'b0;
      dv_seen = 0;
      for (int k = 0; k < 6; k++) begin
         edge_step(1'b1, 8'(8'h51 + k));
         if (o_dv) dv_seen++;
      end
      chk("postreset pulses", dv_seen, 1);
      chk("postreset o_data", o_data,  48'h515253545556);

      // Downstream decode: one write frame then one read frame.
      w0 = w_pulses;
      r0 = r_pulses;
      edge_step(1'b1, 8'h0a);
      edge_step(1'b1, 8'h00);
      edge_step(1'b1, 8'h10);
      edge_step(1'b1, 8'h00);
      edge_step(1'b1, 8'h00);
      edge_step(1'b1, 8'h5a);
      repeat (3) edge_step(1'b0, 8'h00);
      chk("write w_en pulses", w_pulses - w0, 1);
      chk("write r_en pulses", r_pulses - r0, 0);
      edge_step(1'b1, 8'ha0);
      edge_step(1'b1, 8'h00);
      edge_step(1'b1, 8'h10);
      edge_step(1'b1, 8'h00);
      edge_step(1'b1, 8'h00);
      edge_step(1'b1, 8'h00);
      repeat (3) edge_step(1'b0, 8'h00);
      chk("read w_en pulses", w_pulses - w0, 1);
      chk("read r_en pulses", r_pulses - r0, 1);

      // Randomized traffic with occasional long gaps and reset pulses.
      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(0, 399) == 0) begin
            repeat ($urandom_range(T - 5, T + 5)) edge_step(1'b0, 8'($urandom));
         end else if ($urandom_range(0, 999) == 0) begin
            i_word_dv = 1'b0;
            #2 i_reset = 1'b1;
            model_reset();
            #2 i_reset = 1'b0;
         end else begin
            edge_step($urandom_range(0, 99) < 60, 8'($urandom));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
